vector_response_checker: RTL and testbench
==========================================

Name: vector_response_checker

Overview:
- On-chip counterpart to the stimulus/logging bench used for trojan-detection benchmarks.
- Stores a golden list of {stimulus, response} bit pairs.
- During a run, it compares the live DUT stimulus and output against that list, one sample per valid cycle.
- It counts mismatches, latches the first failing vector index, and reports pass/fail. This replaces offline text-dump diffing for single-input/single-output benchmark cores.

Parameters:
- DEPTH, 16, maximum number of golden vectors stored; must be a power of 2, ≥2.
- AW, $clog2(DEPTH), vector index width.
- CW, 8, mismatch counter width; the counter saturates.

Ports:
- CK  input  1  clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-low reset.
- ld_valid  input  1  golden-vector write strobe.
- ld_data  input  2  golden vector; [1] = stimulus N, [0] = expected output.
- ld_ready  output  1  high when a golden write is accepted.
- start  input  1  single-cycle pulse that begins a compare run.
- smp_valid  input  1  live sample valid this cycle.
- smp_stim  input  1  live stimulus bit N driven to the DUT.
- smp_resp  input  1  live DUT output_single.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- pass  output  1  valid when done; 1 if mismatch_cnt == 0.
- mismatch_cnt  output  CW  number of mismatching samples (saturating).
- first_fail_idx  output  AW  index of the first mismatch; 0 if none.
- vec_count  output  AW+1  number of golden vectors loaded.

Behaviour:
- Reset (reset == 0 at a CK edge):
  - FSM goes to LOAD.
  - vec_count, run index, mismatch_cnt and first_fail_idx clear to 0.
  - busy = 0, done = 0, pass = 0.
  - Memory contents are don't-care.
- A reset asserted mid-run aborts the run with the same result; there is no partial reporting.
- FSM states: LOAD, RUN, DONE.
- LOAD:
  - ld_ready = 1 while vec_count < DEPTH.
  - When ld_valid && ld_ready: mem[vec_count] <= ld_data and vec_count increments.
  - Writes at vec_count == DEPTH are dropped; ld_ready = 0.
  - start with vec_count == 0: ignored, stay in LOAD.
  - start with vec_count > 0: go to RUN next cycle; idx, mismatch_cnt and first_fail_idx clear.
  - ld_valid and start in the same cycle: the write takes effect first, and the run includes that vector.
- RUN:
  - busy = 1 and ld_ready = 0; ld_valid is ignored.
  - On smp_valid, compare {smp_stim, smp_resp} with mem[idx]. Any bit difference counts as a mismatch.
  - On a mismatch, mismatch_cnt increments, saturating at 2^CW-1.
  - On the first mismatch of the run, first_fail_idx <= idx.
  - idx increments on each valid sample.
  - When the sample at idx == vec_count-1 is consumed, go to DONE next cycle. Latency from the last sample to done = 1 cycle.
  - Cycles without smp_valid hold all state; there is no timeout.
  - start during RUN is ignored.
- DONE:
  - done = 1, busy = 0.
  - pass = (mismatch_cnt == 0).
  - Results hold until the next start or reset.
  - start in DONE: go to RUN, reusing the loaded vectors; results clear.
  - ld_valid in DONE: return to LOAD with vec_count cleared, and the write is taken as vector 0. done drops the next cycle.
- Outputs are registered; nothing goes combinationally from inputs to outputs except ld_ready, which is decoded from state and count.

Optional Feature:
- Macro CHK_MISR_EN.
- When defined:
  - Adds output signature[15:0]: a 16-bit MISR, polynomial x^16+x^12+x^5+1.
  - It clears on entry to RUN and shifts in {smp_stim, smp_resp} on each smp_valid during RUN.
  - It holds in DONE; reset value 16'h0000.
  - Gives trojan-sensitive compaction that is independent of the golden memory.
- When undefined: no signature port and no MISR logic; all other behaviour is identical.

Test Plan:
- Basic match:
  - Load 2'b00, 2'b11 (N = 0 → out 0, N = 1 → out 1), pulse start.
  - Drive smp {0,0} then {1,1}.
  - Expect done 1 cycle after the second sample, pass = 1, mismatch_cnt = 0, first_fail_idx = 0.
- Trojan flip:
  - Same load; drive {0,0} then {1,0}.
  - Expect pass = 0, mismatch_cnt = 1, first_fail_idx = 1.
- Full and saturation:
  - Load DEPTH+2 vectors.
  - Expect vec_count = 16, ld_ready = 0 after the 16th write, and the extra writes dropped.
  - With CW = 2, run 16 mismatching samples; expect mismatch_cnt = 3 and first_fail_idx = 0.
- Gaps and rerun:
  - Insert 3 idle cycles between samples; expect state held and correct results.
  - Then pulse start in DONE and rerun with all-matching samples; expect the prior results cleared and pass = 1.
- Reset mid-run:
  - After 1 of 2 samples, drive reset = 0 for one edge.
  - Expect LOAD state, vec_count = 0, busy = 0, done = 0, mismatch_cnt = 0.
  - start then ignored until a vector is loaded.
- MISR (CHK_MISR_EN defined):
  - Run the vectors from the basic-match case.
  - Expect signature equal to the reference-model value, and signature = 16'h0000 after reset.

Source files
------------

// File: rtl/vector_response_checker.sv
// vector_response_checker: compares live stimulus/response samples against a stored golden vector list.
// Optional CHK_MISR_EN adds a 16-bit MISR signature of the sampled run.
module vector_response_checker #(
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH),
  parameter int CW = 8
) (
  input  logic          CK,
  input  logic          reset,
  input  logic          ld_valid,
  input  logic [1:0]    ld_data,
  output logic          ld_ready,
  input  logic          start,
  input  logic          smp_valid,
  input  logic          smp_stim,
  input  logic          smp_resp,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] mismatch_cnt,
  output logic [AW-1:0] first_fail_idx,
  output logic [AW:0]   vec_count
`ifdef CHK_MISR_EN
  ,
  output logic [15:0]   signature
`endif
);
  localparam logic [1:0] LOAD = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [AW-1:0] idx;
  logic [1:0] mem [DEPTH];
  logic full, wr, go_run, miss, last;
  assign full = vec_count == (AW+1)'(DEPTH);
  assign ld_ready = (state == LOAD && !full) || state == DONE;
  assign wr = ld_valid && ld_ready;
  // a write in DONE restarts loading, so it must not also start a run
  assign go_run = start && ((state == LOAD && (vec_count != '0 || wr)) || (state == DONE && !ld_valid));
  assign miss = {smp_stim, smp_resp} != mem[idx];
  assign last = {1'b0, idx} == vec_count - 1'b1;
  assign busy = state == RUN;
  assign done = state == DONE;
  assign pass = done && mismatch_cnt == '0;
  always_ff @(posedge CK)
    if (wr) mem[state == DONE ? '0 : vec_count[AW-1:0]] <= ld_data;
  always_ff @(posedge CK) begin
    if (!reset) begin
      state <= LOAD;
      vec_count <= '0;
      idx <= '0;
      mismatch_cnt <= '0;
      first_fail_idx <= '0;
    end else if (go_run) begin
      state <= RUN;
      idx <= '0;
      mismatch_cnt <= '0;
      first_fail_idx <= '0;
      if (state == LOAD && wr) vec_count <= vec_count + 1'b1;
    end else if (state == LOAD) begin
      if (wr) vec_count <= vec_count + 1'b1;
    end else if (state == RUN) begin
      if (smp_valid) begin
        idx <= idx + 1'b1;
        if (miss && mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + 1'b1;
        if (miss && mismatch_cnt == '0) first_fail_idx <= idx;
        if (last) state <= DONE;
      end
    end else if (state == DONE && ld_valid) begin
      state <= LOAD;
      vec_count <= (AW+1)'(1);
    end
  end
`ifdef CHK_MISR_EN
  always_ff @(posedge CK) begin
    if (!reset || go_run) signature <= '0;
    else if (state == RUN && smp_valid)
      signature <= {signature[14:0], 1'b0} ^ (signature[15] ? 16'h1021 : 16'h0000) ^ {14'b0, smp_stim, smp_resp};
  end
`endif
endmodule

// File: tb/tb_vector_response_checker.sv
// tb_vector_response_checker: directed scenario tasks with hand-computed expectations.
module tb_vector_response_checker;
  logic CK = 0, reset = 0, ld_valid = 0, start = 0, smp_valid = 0, smp_stim = 0, smp_resp = 0;
  logic [1:0] ld_data = 0;
  logic ld_ready, busy, done, pass;
  logic [1:0] mismatch_cnt;
  logic [3:0] first_fail_idx;
  logic [4:0] vec_count;
  int checks = 0, errors = 0;
`ifdef CHK_MISR_EN
  logic [15:0] signature;
`endif
  vector_response_checker #(.DEPTH(16), .CW(2)) dut (
    .CK(CK), .reset(reset), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .start(start), .smp_valid(smp_valid), .smp_stim(smp_stim), .smp_resp(smp_resp),
    .busy(busy), .done(done), .pass(pass), .mismatch_cnt(mismatch_cnt),
    .first_fail_idx(first_fail_idx), .vec_count(vec_count)
`ifdef CHK_MISR_EN
    , .signature(signature)
`endif
  );
  always #5 CK = ~CK;

  task automatic step;
    @(posedge CK);
    #1;
  endtask
  task automatic do_reset;
    reset = 0;
    step();
    reset = 1;
  endtask
  task automatic load(input logic [1:0] d);
    ld_valid = 1;
    ld_data = d;
    step();
    ld_valid = 0;
  endtask
  task automatic pulse_start;
    start = 1;
    step();
    start = 0;
  endtask
  task automatic sample(input logic s, input logic r);
    smp_valid = 1;
    smp_stim = s;
    smp_resp = r;
    step();
    smp_valid = 0;
  endtask
  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic test_reset;
    step();
    do_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got=%0b exp=0", pass); end
    checks++; if (mismatch_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", mismatch_cnt); end
    checks++; if (first_fail_idx !== 4'd0) begin errors++; $display("FAIL reset_ffi got=%0d exp=0", first_fail_idx); end
    checks++; if (vec_count !== 5'd0) begin errors++; $display("FAIL reset_vec_count got=%0d exp=0", vec_count); end
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL reset_ld_ready got=%0b exp=1", ld_ready); end
`ifdef CHK_MISR_EN
    checks++; if (signature !== 16'h0000) begin errors++; $display("FAIL reset_sig got=%0h exp=0", signature); end
`endif
  endtask

  task automatic test_basic_match;
    load(2'b00);
    load(2'b11);
    checks++; if (vec_count !== 5'd2) begin errors++; $display("FAIL basic_vec_count got=%0d exp=2", vec_count); end
    pulse_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%0b exp=1", busy); end
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL basic_ld_ready_run got=%0b exp=0", ld_ready); end
    sample(0, 0);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_early got=%0b exp=0", done); end
    sample(1, 1);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done got=%0b exp=1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done got=%0b exp=0", busy); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL basic_pass got=%0b exp=1", pass); end
    checks++; if (mismatch_cnt !== 2'd0) begin errors++; $display("FAIL basic_cnt got=%0d exp=0", mismatch_cnt); end
    checks++; if (first_fail_idx !== 4'd0) begin errors++; $display("FAIL basic_ffi got=%0d exp=0", first_fail_idx); end
`ifdef CHK_MISR_EN
    checks++; if (signature !== 16'h0003) begin errors++; $display("FAIL basic_sig got=%0h exp=0003", signature); end
`endif
  endtask

  task automatic test_trojan_flip;
    load(2'b00);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL trojan_done_drop got=%0b exp=0", done); end
    checks++; if (vec_count !== 5'd1) begin errors++; $display("FAIL trojan_reload_count got=%0d exp=1", vec_count); end
    load(2'b11);
    pulse_start();
    sample(0, 0);
    sample(1, 0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL trojan_done got=%0b exp=1", done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL trojan_pass got=%0b exp=0", pass); end
    checks++; if (mismatch_cnt !== 2'd1) begin errors++; $display("FAIL trojan_cnt got=%0d exp=1", mismatch_cnt); end
    checks++; if (first_fail_idx !== 4'd1) begin errors++; $display("FAIL trojan_ffi got=%0d exp=1", first_fail_idx); end
`ifdef CHK_MISR_EN
    checks++; if (signature !== 16'h0002) begin errors++; $display("FAIL trojan_sig got=%0h exp=0002", signature); end
`endif
  endtask

  task automatic test_full_saturation;
    do_reset();
    for (int i = 0; i < 16; i++) load(2'b01);
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL full_ld_ready got=%0b exp=0", ld_ready); end
    checks++; if (vec_count !== 5'd16) begin errors++; $display("FAIL full_vec_count got=%0d exp=16", vec_count); end
    load(2'b00);
    load(2'b00);
    checks++; if (vec_count !== 5'd16) begin errors++; $display("FAIL full_dropped_count got=%0d exp=16", vec_count); end
    pulse_start();
    for (int i = 0; i < 15; i++) sample(0, 0);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL full_done_early got=%0b exp=0", done); end
    sample(0, 0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL full_done got=%0b exp=1", done); end
    checks++; if (mismatch_cnt !== 2'd3) begin errors++; $display("FAIL full_sat_cnt got=%0d exp=3", mismatch_cnt); end
    checks++; if (first_fail_idx !== 4'd0) begin errors++; $display("FAIL full_ffi got=%0d exp=0", first_fail_idx); end
  endtask

  task automatic test_gaps_rerun;
    do_reset();
    load(2'b10);
    load(2'b01);
    load(2'b11);
    pulse_start();
    sample(1, 0);
    for (int i = 0; i < 3; i++) step();
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL gap_hold busy=%0b done=%0b exp busy=1 done=0", busy, done); end
    sample(0, 0);
    for (int i = 0; i < 3; i++) step();
    checks++; if (mismatch_cnt !== 2'd1) begin errors++; $display("FAIL gap_cnt_hold got=%0d exp=1", mismatch_cnt); end
    sample(1, 1);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL gap_done got=%0b exp=1", done); end
    checks++; if (first_fail_idx !== 4'd1) begin errors++; $display("FAIL gap_ffi got=%0d exp=1", first_fail_idx); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL gap_pass got=%0b exp=0", pass); end
    pulse_start();
    checks++; if (busy !== 1'b1 || mismatch_cnt !== 2'd0 || first_fail_idx !== 4'd0) begin errors++; $display("FAIL rerun_clear busy=%0b cnt=%0d ffi=%0d exp busy=1 cnt=0 ffi=0", busy, mismatch_cnt, first_fail_idx); end
    sample(1, 0);
    pulse_start();
    sample(0, 1);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rerun_start_ignored done=%0b exp=0", done); end
    sample(1, 1);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL rerun_done got=%0b exp=1", done); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL rerun_pass got=%0b exp=1", pass); end
  endtask

  task automatic test_reset_mid_run;
    do_reset();
    load(2'b00);
    load(2'b11);
    pulse_start();
    sample(1, 0);
    checks++; if (mismatch_cnt !== 2'd1) begin errors++; $display("FAIL mid_pre_cnt got=%0d exp=1", mismatch_cnt); end
    do_reset();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_state busy=%0b done=%0b exp 0 0", busy, done); end
    checks++; if (vec_count !== 5'd0) begin errors++; $display("FAIL mid_vec_count got=%0d exp=0", vec_count); end
    checks++; if (mismatch_cnt !== 2'd0) begin errors++; $display("FAIL mid_cnt got=%0d exp=0", mismatch_cnt); end
    pulse_start();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL empty_start got=%0b exp=0", busy); end
    ld_valid = 1;
    ld_data = 2'b11;
    start = 1;
    step();
    ld_valid = 0;
    start = 0;
    checks++; if (busy !== 1'b1 || vec_count !== 5'd1) begin errors++; $display("FAIL load_start busy=%0b vec_count=%0d exp busy=1 vec_count=1", busy, vec_count); end
    sample(1, 1);
    checks++; if (done !== 1'b1 || pass !== 1'b1) begin errors++; $display("FAIL load_start_run done=%0b pass=%0b exp 1 1", done, pass); end
`ifdef CHK_MISR_EN
    do_reset();
    checks++; if (signature !== 16'h0000) begin errors++; $display("FAIL sig_after_reset got=%0h exp=0", signature); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic_match();
    test_trojan_flip();
    test_full_saturation();
    test_gaps_rerun();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
